// File: rtl/int_cmd_pkg.sv
// Shared constants, state encoding and saturating-add helper
// for the integer command parser.
package int_cmd_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hA55A;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_ADD       = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h03;
  localparam logic [7:0] OP_CLEAR_ALL = 8'h04;

  localparam logic [1:0] ERR_SYNC    = 2'd1;
  localparam logic [1:0] ERR_CMD     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    WAIT_DATA = 2'd1,
    EXEC      = 2'd2
  } state_e;

  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

endpackage

// File: rtl/int_cmd_parser_if.sv
// Word stream in, read port and status pulses out.
// The parser takes the slave side.
interface int_cmd_parser_if;
  logic        [31:0] i_int;
  logic               int_avail;
  logic        [7:0]  i_rd_addr;
  logic signed [31:0] o_rd_data;
  logic               o_upd;
  logic        [7:0]  o_upd_addr;
  logic               o_err;
  logic        [1:0]  o_err_code;

  modport slave (
    input  i_int, int_avail, i_rd_addr,
    output o_rd_data, o_upd, o_upd_addr,
    output o_err, o_err_code
  );

  modport master (
    output i_int, int_avail, i_rd_addr,
    input  o_rd_data, o_upd, o_upd_addr,
    input  o_err, o_err_code
  );
endinterface

// File: rtl/cmd_reg_bank.sv
// Setpoint register bank: one write port with write/add/clear/
// clear-all modes and a registered, range-checked read port.
module cmd_reg_bank
  import int_cmd_pkg::*;
#(
  parameter int N_REGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic        [7:0]  op,
  input  logic        [7:0]  waddr,
  input  logic signed [31:0] wdata,
  input  logic        [7:0]  raddr,
  output logic signed [31:0] rdata
);

  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic signed [31:0] bank_q [N_REGS];
  logic signed [31:0] bank_d [N_REGS];
  logic signed [31:0] rdata_q, rdata_d;
  logic [AW-1:0] wi, ri;

  assign wi = waddr[AW-1:0];
  assign ri = raddr[AW-1:0];

  always_comb begin
    bank_d = bank_q;
    if (we) begin
      unique case (op)
        OP_WRITE: bank_d[wi] = wdata;
        OP_ADD:   bank_d[wi] = sat_add(bank_q[wi], wdata);
        OP_CLEAR: bank_d[wi] = '0;
        OP_CLEAR_ALL:
          for (int i = 0; i < N_REGS; i++) bank_d[i] = '0;
        default: ;
      endcase
    end
    // out-of-range reads return zero rather than aliasing
    rdata_d = (32'(raddr) < N_REGS) ? bank_q[ri] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) bank_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      bank_q  <= bank_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/int_cmd_parser.sv
// Frames received words into header/data commands and applies
// them to the setpoint bank; flags rejects and timeouts.
module int_cmd_parser
  import int_cmd_pkg::*;
#(
  parameter int N_REGS         = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  int_cmd_parser_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic prev_avail_q, prev_avail_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic signed [31:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic upd_q, upd_d;
  logic [7:0] upd_addr_q, upd_addr_d;
  logic err_q, err_d;
  logic [1:0] err_code_q, err_code_d;

  logic acc, sync_ok, addr_ok, need_data, is_clr, is_clra;
  logic [7:0] hop, haddr;
  logic bank_we;

  assign acc       = !prev_avail_q && bus.int_avail;
  assign hop       = bus.i_int[15:8];
  assign haddr     = bus.i_int[7:0];
  assign sync_ok   = bus.i_int[31:16] == SYNC_WORD;
  assign addr_ok   = 32'(haddr) < N_REGS;
  assign need_data = hop == OP_WRITE || hop == OP_ADD;
  assign is_clr    = hop == OP_CLEAR;
  assign is_clra   = hop == OP_CLEAR_ALL;
  assign bank_we   = state_q == EXEC;

  always_comb begin
    state_d      = state_q;
    prev_avail_d = bus.int_avail;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    upd_d        = 1'b0;
    upd_addr_d   = upd_addr_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    case (state_q)
      HUNT: if (acc) begin
        op_d   = hop;
        addr_d = haddr;
        unique case (1'b1)
          !sync_ok: begin
            err_d      = 1'b1;
            err_code_d = ERR_SYNC;
          end
          need_data && addr_ok: begin
            cnt_d   = '0;
            state_d = WAIT_DATA;
          end
          is_clr && addr_ok: state_d = EXEC;
          is_clra:           state_d = EXEC;
          default: begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
          end
        endcase
      end
      WAIT_DATA: begin
        // a word on the expiry edge still completes the frame
        if (acc) begin
          data_d  = bus.i_int;
          state_d = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = HUNT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        upd_d      = 1'b1;
        upd_addr_d = (op_q == OP_CLEAR_ALL) ? 8'hFF : addr_q;
        state_d    = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      prev_avail_q <= 1'b1;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      upd_q        <= 1'b0;
      upd_addr_q   <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_avail_q <= prev_avail_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      upd_q        <= upd_d;
      upd_addr_q   <= upd_addr_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  cmd_reg_bank #(.N_REGS(N_REGS)) u_bank (
    .clk   (clk),
    .rst_n (rst),
    .we    (bank_we),
    .op    (op_q),
    .waddr (addr_q),
    .wdata (data_q),
    .raddr (bus.i_rd_addr),
    .rdata (bus.o_rd_data)
  );

  assign bus.o_upd      = upd_q;
  assign bus.o_upd_addr = upd_addr_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;

endmodule

// File: tb/tb_int_cmd_parser.sv
// Directed bench for int_cmd_parser: vector table plus
// timeout and mid-frame reset sequences.
module tb_int_cmd_parser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int upd_n = 0;
  int err_n = 0;
  logic [7:0] last_uaddr = '0;
  logic [1:0] last_code = '0;

  int_cmd_parser_if bus();

  int_cmd_parser #(
    .N_REGS(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_upd) begin
      upd_n = upd_n + 1;
      last_uaddr = bus.o_upd_addr;
    end
    if (bus.o_err) begin
      err_n = err_n + 1;
      last_code = bus.o_err_code;
    end
  end

  typedef struct {
    logic [31:0] hdr;
    bit          has_data;
    logic [31:0] data;
    logic [7:0]  rd;
    bit          upd;
    logic [7:0]  uaddr;
    bit          err;
    logic [1:0]  code;
    logic [31:0] rdv;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // low for one cycle, then high: acceptance on the next edge
  task automatic send_word(input logic [31:0] w);
    @(posedge clk); #1;
    bus.int_avail = 1'b0;
    bus.i_int = w;
    @(posedge clk); #1;
    bus.int_avail = 1'b1;
  endtask

  task automatic read_chk(input string nm,
                          input logic [7:0] a,
                          input logic [31:0] exp);
    @(posedge clk); #1;
    bus.i_rd_addr = a;
    @(posedge clk); #1;
    chk(nm, bus.o_rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, e0;
    v[0]  = '{32'hA55A0103, 1, 32'hFFFFFFF6, 8'd3,
              1, 8'd3, 0, 2'd0, 32'hFFFFFFF6};
    v[1]  = '{32'hA55A0102, 1, 32'h7FFFFFF0, 8'd2,
              1, 8'd2, 0, 2'd0, 32'h7FFFFFF0};
    v[2]  = '{32'hA55A0202, 1, 32'h00000100, 8'd2,
              1, 8'd2, 0, 2'd0, 32'h7FFFFFFF};
    v[3]  = '{32'hA55A0102, 1, 32'h80000010, 8'd2,
              1, 8'd2, 0, 2'd0, 32'h80000010};
    v[4]  = '{32'hA55A0202, 1, 32'h80000000, 8'd2,
              1, 8'd2, 0, 2'd0, 32'h80000000};
    v[5]  = '{32'hA55A0202, 1, 32'h80000000, 8'd2,
              1, 8'd2, 0, 2'd0, 32'h80000000};
    v[6]  = '{32'h12345678, 0, 32'h0, 8'd2,
              0, 8'd0, 1, 2'd1, 32'h80000000};
    v[7]  = '{32'hA55A0109, 0, 32'h0, 8'd3,
              0, 8'd0, 1, 2'd2, 32'hFFFFFFF6};
    v[8]  = '{32'hA55A0703, 0, 32'h0, 8'd3,
              0, 8'd0, 1, 2'd2, 32'hFFFFFFF6};
    v[9]  = '{32'hA55A0107, 1, 32'h00000011, 8'd7,
              1, 8'd7, 0, 2'd0, 32'h00000011};
    v[10] = '{32'hA55A0307, 0, 32'h0, 8'd7,
              1, 8'd7, 0, 2'd0, 32'h00000000};
    v[11] = '{32'hA55A0308, 0, 32'h0, 8'd8,
              0, 8'd0, 1, 2'd2, 32'h00000000};
    v[12] = '{32'hA55A0206, 1, 32'hFFFFFFFF, 8'd6,
              1, 8'd6, 0, 2'd0, 32'hFFFFFFFF};
    v[13] = '{32'hA55A0404, 0, 32'h0, 8'd3,
              1, 8'hFF, 0, 2'd0, 32'h00000000};
    v[14] = '{32'hA55A01FF, 0, 32'h0, 8'd6,
              0, 8'd0, 1, 2'd2, 32'h00000000};

    // reset with a bad word already present and level high
    bus.i_int = 32'h12345678;
    bus.int_avail = 1'b1;
    bus.i_rd_addr = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", bus.o_rd_data, 32'h0);
    chk("rst_upd", {31'd0, bus.o_upd}, 32'd0);
    chk("rst_err", {31'd0, bus.o_err}, 32'd0);
    chk("rst_code", {30'd0, bus.o_err_code}, 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rel_no_err", err_n, 0);
    chk("rel_no_upd", upd_n, 0);

    for (int i = 0; i < 15; i++) begin
      u0 = upd_n;
      e0 = err_n;
      send_word(v[i].hdr);
      if (v[i].has_data) send_word(v[i].data);
      repeat (4) @(posedge clk);
      #1;
      bus.i_rd_addr = v[i].rd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_upd_n", i), upd_n - u0,
          {31'd0, v[i].upd});
      chk($sformatf("v%0d_err_n", i), err_n - e0,
          {31'd0, v[i].err});
      if (v[i].upd)
        chk($sformatf("v%0d_uaddr", i), {24'd0, last_uaddr},
            {24'd0, v[i].uaddr});
      if (v[i].err)
        chk($sformatf("v%0d_code", i),
            {30'd0, bus.o_err_code}, {30'd0, v[i].code});
      chk($sformatf("v%0d_rd", i), bus.o_rd_data, v[i].rdv);
    end

    // timeout: header, then no new edge for 100 cycles
    u0 = upd_n;
    e0 = err_n;
    send_word(32'hA55A0101);
    @(posedge clk);
    repeat (99) @(posedge clk);
    #1;
    chk("to_early", {31'd0, bus.o_err}, 32'd0);
    @(posedge clk); #1;
    chk("to_err", {31'd0, bus.o_err}, 32'd1);
    chk("to_code", {30'd0, bus.o_err_code}, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("to_no_upd", upd_n - u0, 0);
    chk("to_err_n", err_n - e0, 1);

    // data edge lands exactly on the expiry edge
    u0 = upd_n;
    e0 = err_n;
    send_word(32'hA55A0101);
    @(posedge clk);
    @(posedge clk); #1;
    bus.int_avail = 1'b0;
    bus.i_int = 32'h00000055;
    repeat (98) @(posedge clk);
    #1;
    bus.int_avail = 1'b1;
    @(posedge clk); #1;
    chk("race_no_err", {31'd0, bus.o_err}, 32'd0);
    @(posedge clk); #1;
    chk("race_upd", {31'd0, bus.o_upd}, 32'd1);
    chk("race_uaddr", {24'd0, bus.o_upd_addr}, 32'd1);
    read_chk("race_rd", 8'd1, 32'h00000055);
    chk("race_err_n", err_n - e0, 0);

    // reset in the middle of a frame
    send_word(32'hA55A0104);
    send_word(32'h00000009);
    repeat (4) @(posedge clk);
    read_chk("pre_rst_rd4", 8'd4, 32'h00000009);
    send_word(32'hA55A0105);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_int = 32'h00000007;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_rd", bus.o_rd_data, 32'h0);
    chk("mid_rst_code", {30'd0, bus.o_err_code}, 32'd0);
    u0 = upd_n;
    e0 = err_n;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rel_err_n", err_n - e0, 0);
    send_word(32'h00000007);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_err_n", err_n - e0, 1);
    chk("mid_code", {30'd0, last_code}, 32'd1);
    chk("mid_no_upd", upd_n - u0, 0);
    read_chk("mid_rd5", 8'd5, 32'h0);
    read_chk("mid_rd4", 8'd4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/int_cmd_parser.md
# int_cmd_parser

Downstream consumer of the 32-bit UART integer receiver. It interprets the stream of received signed 32-bit words as two-word command frames (header + data) or one-word frames (header only) and applies them to an internal bank of signed 32-bit setpoint registers. A registered read port feeds the rest of the controller, and update/error pulses feed status logic.

## Interface
- N_REGS, 8: number of setpoint registers, 2..256.
- TIMEOUT_CYCLES, 50_000_000: maximum number of idle cycles between a header and its data word.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_int  in  32  signed word from the integer receiver; valid whenever int_avail is high.
- int_avail  in  1  level from the integer receiver; stays high until the next word starts arriving.
- i_rd_addr  in  8  read-port register index.
- o_rd_data  out  32  signed; registered read of bank[i_rd_addr].
- o_upd  out  1  one-cycle pulse when a register (or the whole bank) changes.
- o_upd_addr  out  8  index that was updated; 0xFF for CLEAR_ALL.
- o_err  out  1  one-cycle pulse when a frame is rejected.
- o_err_code  out  2  1 = bad sync, 2 = bad opcode or address, 3 = timeout; holds its value until the next error.

## Operation
- **Word acceptance**
  - A word is accepted on a rising edge of int_avail, detected as prev_avail == 0 and int_avail == 1.
  - prev_avail is registered every cycle and resets to 1, so a level already high when reset releases is not accepted as a word.
- **Header format**
  - [31:16] = SYNC 0xA55A.
  - [15:8] = opcode.
  - [7:0] = register address.
- **Opcodes**
  - 0x01 WRITE: bank[addr] = data.
  - 0x02 ADD: bank[addr] = sat(bank[addr] + data). The sum is computed 33 bits wide and clamped to 0x7FFFFFFF or 0x80000000.
  - 0x03 CLEAR: bank[addr] = 0. No data word.
  - 0x04 CLEAR_ALL: all entries = 0. Address is ignored. No data word.
- **State machine**
  - HUNT
    - Accepted word with a bad sync → o_err, code 1; stay in HUNT.
    - Unknown opcode, or addr >= N_REGS for opcodes 1–3 → o_err, code 2; stay in HUNT.
    - WRITE or ADD → latch opcode and addr, clear the timeout counter, go to WAIT_DATA.
    - CLEAR or CLEAR_ALL → go to EXEC.
  - WAIT_DATA
    - Accepted word → latch it as data, go to EXEC.
    - Otherwise increment the counter. On reaching TIMEOUT_CYCLES → o_err, code 3; go to HUNT.
    - If a word arrives in the same cycle the counter expires, the word wins and no timeout is flagged.
    - The data word is never checked for sync.
  - EXEC: perform the bank write, pulse o_upd with o_upd_addr, return to HUNT unconditionally. No word can be accepted in EXEC: the upstream stage needs at least 40 cycles per word.
- **Read port**: o_rd_data <= (i_rd_addr < N_REGS) ? bank[i_rd_addr] : 0.
- **Reset** (at any point, including mid-frame)
  - State → HUNT; bank all zero.
  - o_rd_data, o_upd, o_upd_addr, o_err and o_err_code all 0.
  - Counter and latches cleared. A partial frame is discarded.

## Timing
- Word accepted at edge E → state change at E.
- For WRITE/ADD/CLEAR/CLEAR_ALL, the bank is updated at E+1.
- o_upd is high for exactly the one cycle after E+1.
- o_err goes high for one cycle after the acceptance edge that rejects the frame, or after the expiring edge for a timeout.
- Read latency is 1 cycle. A read of the register written at edge E+1 returns the new value when sampled at edge E+2 or later.
- Timeout timing: the expiry edge is the TIMEOUT_CYCLES-th edge after header acceptance.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

## Structure
- **Package int_cmd_pkg** holds:
  - SYNC_WORD.
  - Opcode constants OP_WRITE, OP_ADD, OP_CLEAR, OP_CLEAR_ALL.
  - Error codes ERR_SYNC, ERR_CMD, ERR_TIMEOUT.
  - State encoding HUNT, WAIT_DATA, EXEC (2 bits).
- **Sub-module cmd_reg_bank**:
  - N_REGS × 32 signed registers with async clear.
  - Single write port with write, saturating-add, clear and clear-all modes.
  - Registered read port.
- **Parser FSM**: lives in int_cmd_parser.

## Test plan
1. Send header 0xA55A0103, then data 0xFFFFFFF6 → bank[3] = -10; o_upd pulses once with o_upd_addr = 3; o_rd_data reads 0xFFFFFFF6 at i_rd_addr = 3.
2. With bank[2] = 0x7FFFFFF0, send ADD header 0xA55A0202, then 0x00000100 → bank[2] = 0x7FFFFFFF. Then ADD 0x80000000 twice with bank[2] = 0x80000010 → 0x80000000.
3. Send word 0x12345678 → o_err with code 1, no o_upd. Then send header 0xA55A0109 with N_REGS = 8 → code 2. Then send 0xA55A0404 → all registers 0 and o_upd_addr = 0xFF.
4. With TIMEOUT_CYCLES = 100, send header 0xA55A0101 and hold int_avail high with no new edge for 100 cycles → o_err code 3 on the 100th edge, no update. A second run with the data edge on exactly the 100th edge must perform the update instead.
5. Deassert rst between header 0xA55A0105 and its data, then send 0x00000007 after release → no update (the word is rejected as bad sync, code 1), and bank[5] = 0. int_avail held high through reset release produces no acceptance.
